// File: rtl/boxcar_pkg.sv
// rtl/boxcar_pkg.sv - shared state and tag types for the boxcar frame sequencer
package boxcar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    DRAIN
  } state_t;

  localparam int TAG_W = 3;

  // One tag travels alongside every filter ce so the output stage knows what the result means.
  typedef struct packed {
    logic vld;
    logic warm;
    logic last;
  } tag_t;

endpackage

// File: rtl/boxcar_tag_pipe.sv
// rtl/boxcar_tag_pipe.sv - fixed-depth tag delay line matching the filter latency
module boxcar_tag_pipe
  import boxcar_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_clear,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t stages [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign o_tag = stages[DEPTH-1];

endmodule

// File: rtl/boxcar_frame_sequencer.sv
// rtl/boxcar_frame_sequencer.sv - per-frame clear, feed, flush and re-framing around a boxcar filter
module boxcar_frame_sequencer
  import boxcar_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_SAMPLES  = 2,
  parameter int FILT_LATENCY = 1,
  parameter int DROP_WARMUP  = 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_last,
  output logic                         o_filt_reset_n,
  output logic                         o_filt_ce,
  output logic signed [DATA_WIDTH-1:0] o_filt_data,
  input  logic                         i_filt_ce,
  input  logic signed [DATA_WIDTH-1:0] i_filt_data,
  output logic                         m_valid,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam int DW = $clog2(FILT_LATENCY + 2);
  localparam logic [CW-1:0] WARM_MAX   = CW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'((NUM_SAMPLES > 1) ? NUM_SAMPLES - 2 : 0);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(FILT_LATENCY);

  state_t          state;
  logic [CW-1:0]   warm_cnt;
  logic [CW-1:0]   flush_cnt;
  logic [DW-1:0]   drain_cnt;
  tag_t            ce_tag;
  tag_t            pipe_tag;
  logic            accept;
  logic            warm_now;
  logic            emit;

  assign s_ready        = (state == RUN);
  assign o_busy         = (state != IDLE);
  assign o_filt_reset_n = !(i_reset || state == CLEAR);
  assign accept         = s_valid && s_ready;
  assign warm_now       = (warm_cnt != WARM_MAX);
  assign emit           = pipe_tag.vld && !((DROP_WARMUP != 0) && pipe_tag.warm);

  boxcar_tag_pipe #(.DEPTH(FILT_LATENCY)) u_tag_pipe (
    .i_clk   (i_clk),
    .i_clear (i_reset),
    .i_tag   (ce_tag),
    .o_tag   (pipe_tag)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      warm_cnt    <= '0;
      flush_cnt   <= '0;
      drain_cnt   <= '0;
      ce_tag      <= '0;
      o_filt_ce   <= 1'b0;
      o_filt_data <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_filt_ce <= 1'b0;
      ce_tag    <= '0;
      case (state)
        IDLE: if (s_valid) state <= CLEAR;
        CLEAR: begin
          warm_cnt  <= '0;
          flush_cnt <= '0;
          state     <= RUN;
        end
        RUN: if (accept) begin
          o_filt_ce   <= 1'b1;
          o_filt_data <= s_data;
          ce_tag      <= '{vld: 1'b1, warm: warm_now, last: s_last && (NUM_SAMPLES == 1)};
          if (warm_now) warm_cnt <= warm_cnt + 1'b1;
          if (s_last) begin
            flush_cnt <= '0;
            drain_cnt <= '0;
            state     <= (NUM_SAMPLES > 1) ? FLUSH : DRAIN;
          end
        end
        // Zeros push the frame's tail through the window so every sample reaches the output.
        FLUSH: begin
          o_filt_ce   <= 1'b1;
          o_filt_data <= '0;
          ce_tag      <= '{vld: 1'b1, warm: warm_now, last: flush_cnt == FLUSH_LAST};
          if (warm_now) warm_cnt <= warm_cnt + 1'b1;
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == FLUSH_LAST) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= IDLE;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      m_valid <= emit;
      m_last  <= emit && pipe_tag.last;
      if (emit) m_data <= i_filt_data;
      if (pipe_tag.vld != i_filt_ce) o_err <= 1'b1;
    end
  end

endmodule
